// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared types and defaults for the motion-estimation window loader
package me_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_R,
        LOAD_S,
        RUN,
        GAP,
        CAPTURE
    } state_t;

    localparam int CNT_W          = 13;
    localparam int R_DEPTH_DEF    = 256;
    localparam int S_DEPTH_DEF    = 1024;
    localparam int RUN_CYCLES_DEF = 4112;

    localparam logic [7:0] NOT_FOUND = 8'hFF;

endpackage

// File: rtl/me_window_loader.sv
// rtl/me_window_loader.sv - streams reference/search windows into the ME core memories,
// runs the core for a fixed time and captures its sign-decoded result
module me_window_loader
    import me_pkg::*;
#(
    parameter int R_DEPTH    = R_DEPTH_DEF,
    parameter int S_DEPTH    = S_DEPTH_DEF,
    parameter int RUN_CYCLES = RUN_CYCLES_DEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load_req,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        r_we,
    output logic [7:0]  r_addr,
    output logic        s_we,
    output logic [9:0]  s_addr,
    output logic [7:0]  wdata,
    output logic        start,
    input  logic [7:0]  BestDist,
    input  logic [3:0]  motionX,
    input  logic [3:0]  motionY,
    output logic        busy,
    output logic        res_valid,
    output logic [7:0]  res_dist,
    output logic signed [3:0] res_mv_x,
    output logic signed [3:0] res_mv_y,
    output logic        res_found,
    output logic        res_perf
);

    localparam logic [CNT_W-1:0] R_LAST   = CNT_W'(R_DEPTH - 1);
    localparam logic [CNT_W-1:0] S_LAST   = CNT_W'(S_DEPTH - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic             accept;

    assign in_ready = (state == LOAD_R) || (state == LOAD_S);
    assign accept   = in_valid & in_ready;
    assign busy     = (state != IDLE);
    assign wdata    = in_data;

    assign r_we   = accept && (state == LOAD_R);
    assign r_addr = (state == LOAD_R) ? count[7:0] : 8'd0;
    assign s_we   = accept && (state == LOAD_S);
    assign s_addr = (state == LOAD_S) ? count[9:0] : 10'd0;

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (load_req) state_next = LOAD_R;
            end
            LOAD_R: begin
                if (accept) begin
                    count_next = count + 1'b1;
                    if (count == R_LAST) state_next = LOAD_S;
                end
            end
            LOAD_S: begin
                if (accept) begin
                    count_next = count + 1'b1;
                    if (count == S_LAST) state_next = RUN;
                end
            end
            RUN: begin
                count_next = count + 1'b1;
                if (count == RUN_LAST) state_next = GAP;
            end
            GAP:     state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // every state entry restarts the shared counter
        if (state_next != state) count_next = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
            start <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            start <= (state_next == RUN);
        end
    end

    // Flags are registered so they read 0 out of reset rather than reflecting res_dist=0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            res_valid <= 1'b0;
            res_dist  <= 8'd0;
            res_mv_x  <= 4'sd0;
            res_mv_y  <= 4'sd0;
            res_found <= 1'b0;
            res_perf  <= 1'b0;
        end else if (state == CAPTURE) begin
            res_valid <= 1'b1;
            res_dist  <= BestDist;
            res_mv_x  <= $signed(motionX);
            res_mv_y  <= $signed(motionY);
            res_found <= (BestDist != NOT_FOUND);
            res_perf  <= (BestDist == 8'h00);
        end else if (state == IDLE && load_req) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_me_window_loader.sv
// tb/tb_me_window_loader.sv - directed bench with a cycle-level behavioural model of the window loader
module tb_me_window_loader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_req = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic [7:0]  BestDist = 8'd0;
    logic [3:0]  motionX = 4'd0;
    logic [3:0]  motionY = 4'd0;
    logic        in_ready, r_we, s_we, start, busy, res_valid, res_found, res_perf;
    logic [7:0]  r_addr, wdata, res_dist;
    logic [9:0]  s_addr;
    logic signed [3:0] res_mv_x, res_mv_y;

    me_window_loader dut (
        .clock(clock), .reset_n(reset_n), .load_req(load_req),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .r_we(r_we), .r_addr(r_addr), .s_we(s_we), .s_addr(s_addr), .wdata(wdata),
        .start(start), .BestDist(BestDist), .motionX(motionX), .motionY(motionY),
        .busy(busy), .res_valid(res_valid), .res_dist(res_dist),
        .res_mv_x(res_mv_x), .res_mv_y(res_mv_y), .res_found(res_found), .res_perf(res_perf)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // model: phase 0 idle, 1 loading, 2 running, 3 gap/capture
    int m_phase = 0, m_n = 0, m_t = 0;
    int m_rv = 0, m_dist = 0, m_mx = 0, m_my = 0, m_found = 0, m_perf = 0;
    int cyc = 0, ready_cycles = 0, start_cycles = 0;
    int last_byte_cyc = 0, start_rise_cyc = 0, rv_rise_cyc = 0;
    logic prev_start = 1'b0, prev_rv = 1'b0;
    logic [7:0] rmem [256];
    logic [7:0] smem [1024];
    int rhits [256];
    int shits [1024];

    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            m_phase = 0; m_n = 0; m_t = 0;
            m_rv = 0; m_dist = 0; m_mx = 0; m_my = 0; m_found = 0; m_perf = 0;
        end
        chk("in_ready", in_ready, m_phase == 1);
        chk("busy", busy, m_phase != 0);
        chk("start", start, m_phase == 2);
        chk("r_we", r_we, (m_phase == 1 && m_n < 256 && in_valid) ? 1 : 0);
        chk("r_addr", r_addr, (m_phase == 1 && m_n < 256) ? m_n : 0);
        chk("s_we", s_we, (m_phase == 1 && m_n >= 256 && in_valid) ? 1 : 0);
        chk("s_addr", s_addr, (m_phase == 1 && m_n >= 256) ? m_n - 256 : 0);
        if (r_we || s_we) chk("wdata", wdata, in_data);
        chk("res_valid", res_valid, m_rv);
        chk("res_dist", res_dist, m_dist);
        chk("res_mv_x", int'(res_mv_x), m_mx);
        chk("res_mv_y", int'(res_mv_y), m_my);
        chk("res_found", res_found, m_found);
        chk("res_perf", res_perf, m_perf);

        if (in_ready) ready_cycles++;
        if (r_we) begin rmem[r_addr] = wdata; rhits[r_addr]++; end
        if (s_we) begin smem[s_addr] = wdata; shits[s_addr]++; end
        if (start) start_cycles++;
        if (start && !prev_start) start_rise_cyc = cyc;
        if (res_valid && !prev_rv) rv_rise_cyc = cyc;
        prev_start = start;
        prev_rv = res_valid;

        if (reset_n) begin
            case (m_phase)
                0: if (load_req) begin
                    m_phase = 1; m_n = 0; m_rv = 0;
                    ready_cycles = 0; start_cycles = 0;
                    for (int i = 0; i < 256; i++) rhits[i] = 0;
                    for (int i = 0; i < 1024; i++) shits[i] = 0;
                end
                1: if (in_valid) begin
                    if (m_n == 1279) begin
                        m_phase = 2; m_t = 0; last_byte_cyc = cyc;
                    end
                    m_n++;
                end
                2: if (m_t == 4111) begin m_phase = 3; m_t = 0; end else m_t++;
                default: if (m_t == 0) m_t = 1;
                    else begin
                        m_phase = 0; m_rv = 1; m_dist = BestDist;
                        m_mx = (motionX >= 4'd8) ? int'(motionX) - 16 : int'(motionX);
                        m_my = (motionY >= 4'd8) ? int'(motionY) - 16 : int'(motionY);
                        m_found = (BestDist != 8'hFF) ? 1 : 0;
                        m_perf = (BestDist == 8'h00) ? 1 : 0;
                    end
            endcase
        end
    end

    int seed = 0;

    function automatic logic [7:0] stream_byte(input int i, input int s);
        return 8'((i * 37) + (s * 11) + (i >> 8));
    endfunction

    task automatic pulse_load();
        @(posedge clock); #1 load_req = 1'b1;
        @(posedge clock); #1 load_req = 1'b0;
    endtask

    task automatic stream(input bit bubbles, input int abort_at);
        for (int i = 0; i < 1280; i++) begin
            if (i == abort_at) begin
                in_valid = 1'b0;
                reset_n = 1'b0;
                @(negedge clock);
                chk("abort_start", start, 0);
                chk("abort_busy", busy, 0);
                chk("abort_ready", in_ready, 0);
                @(posedge clock); #1 reset_n = 1'b1;
                return;
            end
            if (bubbles) begin
                in_valid = 1'b0;
                @(posedge clock); #1;
            end
            in_valid = 1'b1;
            in_data = stream_byte(i, seed);
            @(negedge clock);
            if (i == 0) begin
                chk("first_r_we", r_we, 1);
                chk("first_r_addr", r_addr, 0);
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result();
        for (int k = 0; k < 6000; k++) begin
            @(negedge clock);
            if (res_valid) break;
        end
        #1;
        chk("result_arrived", res_valid, 1);
    endtask

    task automatic check_mems();
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (rhits[i] != 1 || rmem[i] != stream_byte(i, seed)) bad++;
        chk("rmem_bad_entries", bad, 0);
        bad = 0;
        for (int i = 0; i < 1024; i++)
            if (shits[i] != 1 || smem[i] != stream_byte(256 + i, seed)) bad++;
        chk("smem_bad_entries", bad, 0);
    endtask

    initial begin
        // reset
        repeat (3) @(negedge clock);
        chk("rst_start", start, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        @(posedge clock); #1 reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_in_ready", in_ready, 0);
        chk("post_rst_busy", busy, 0);

        // streaming load, perfect match at (-3, 3)
        seed = 1; BestDist = 8'h00; motionX = 4'hD; motionY = 4'h3;
        pulse_load();
        stream(1'b0, -1);
        wait_result();
        chk("stream_ready_cycles", ready_cycles, 1280);
        chk("stream_start_cycles", start_cycles, 4112);
        chk("start_after_last_byte", start_rise_cyc - last_byte_cyc, 1);
        chk("result_latency", rv_rise_cyc - start_rise_cyc, 4114);
        chk("cap_mv_x", int'(res_mv_x), -3);
        chk("cap_mv_y", int'(res_mv_y), 3);
        chk("cap_perf", res_perf, 1);
        chk("cap_found", res_found, 1);
        chk("model_pin_mx", m_mx, -3);
        check_mems();

        // bubbled load, not-found result
        seed = 2; BestDist = 8'hFF; motionX = 4'h7; motionY = 4'h8;
        pulse_load();
        stream(1'b1, -1);
        wait_result();
        chk("bubble_ready_cycles", ready_cycles, 2560);
        chk("bubble_start_cycles", start_cycles, 4112);
        chk("nf_found", res_found, 0);
        chk("nf_perf", res_perf, 0);
        chk("nf_mv_x", int'(res_mv_x), 7);
        chk("nf_mv_y", int'(res_mv_y), -8);
        check_mems();

        // abort at search byte 500, then reload with load_req pulsed during RUN
        seed = 3;
        pulse_load();
        stream(1'b0, 256 + 500);
        seed = 4; BestDist = 8'h10; motionX = 4'h0; motionY = 4'h0;
        pulse_load();
        stream(1'b0, -1);
        repeat (100) @(posedge clock);
        #1 load_req = 1'b1;
        @(posedge clock); #1 load_req = 1'b0;
        wait_result();
        chk("runreq_start_cycles", start_cycles, 4112);
        chk("abort_dist", res_dist, 16);
        check_mems();

        // back-to-back: new load while a result is held
        seed = 5; BestDist = 8'h42; motionX = 4'h1; motionY = 4'hF;
        @(posedge clock); #1 load_req = 1'b1;
        @(posedge clock); #1 load_req = 1'b0;
        @(negedge clock);
        chk("b2b_res_valid_cleared", res_valid, 0);
        chk("b2b_in_ready", in_ready, 1);
        @(posedge clock); #1;
        stream(1'b0, -1);
        wait_result();
        chk("b2b_dist", res_dist, 8'h42);
        chk("b2b_mv_x", int'(res_mv_x), 1);
        chk("b2b_mv_y", int'(res_mv_y), -1);
        chk("b2b_found", res_found, 1);
        chk("b2b_perf", res_perf, 0);
        check_mems();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
